// File: rtl/regfile_multiport.sv
// Multi-ported integer register bank: two async read ports, one sync write port, debug read port.
// The storage array carries no reset; a post-reset sequencer sweeps zeros into it instead.
module regfile_multiport #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREGS    = 32,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1,
  localparam int unsigned ADDR_W  = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       instruction,
  input  logic              reg_write,
  input  logic [XLEN-1:0]   write_data,
  output logic [XLEN-1:0]   read_data_1,
  output logic [XLEN-1:0]   read_data_2,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [XLEN-1:0]   dbg_data,
  output logic              init_done
);

  typedef enum logic [0:0] {StClear, StRun} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
  logic              init_done_q, init_done_d;

  logic [XLEN-1:0]   ram_q [NREGS];

  logic [ADDR_W-1:0] rs1, rs2, rd;
  logic              run, wr_en, clr_last;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [XLEN-1:0]   mem_wdata;
  logic              unused_instr;

  // Only the low ADDR_W bits of each register field select a register.
  assign rs1 = instruction[15 +: ADDR_W];
  assign rs2 = instruction[20 +: ADDR_W];
  assign rd  = instruction[7 +: ADDR_W];
  assign unused_instr = ^instruction;

  assign run      = (state_q == StRun);
  assign clr_last = (clr_idx_q == ADDR_W'(NREGS - 1));
  assign wr_en    = run && reg_write && !(ZERO_REG && (rd == '0));

  always_comb begin
    state_d     = state_q;
    clr_idx_d   = clr_idx_q;
    init_done_d = init_done_q;
    if (state_q == StClear) begin
      if (clr_last) begin
        state_d     = StRun;
        init_done_d = 1'b1;
      end else begin
        clr_idx_d = clr_idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StClear;
      clr_idx_q   <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_idx_q   <= clr_idx_d;
      init_done_q <= init_done_d;
    end
  end

  // Clear sweep owns the write port until the sequencer reaches RUN.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = rd;
    mem_wdata = write_data;
    if (!run) begin
      mem_we    = 1'b1;
      mem_waddr = clr_idx_q;
      mem_wdata = '0;
    end else if (wr_en) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      ram_q[mem_waddr] <= mem_wdata;
    end
  end

  always_comb begin
    read_data_1 = ram_q[rs1];
    if (!run || (ZERO_REG && (rs1 == '0))) begin
      read_data_1 = '0;
    end else if (BYPASS && wr_en && (rd == rs1)) begin
      read_data_1 = write_data;
    end
  end

  always_comb begin
    read_data_2 = ram_q[rs2];
    if (!run || (ZERO_REG && (rs2 == '0))) begin
      read_data_2 = '0;
    end else if (BYPASS && wr_en && (rd == rs2)) begin
      read_data_2 = write_data;
    end
  end

  always_comb begin
    dbg_data = ram_q[dbg_addr];
    if (!run || (ZERO_REG && (dbg_addr == '0))) begin
      dbg_data = '0;
    end
  end

  assign init_done = init_done_q;

endmodule

// File: tb/tb_regfile_multiport.sv
// Bench for regfile_multiport: default build, a no-bypass build and an XLEN=64/NREGS=16 build
// share clock, reset and instruction word.
module tb_regfile_multiport;

  logic        clk;
  logic        rst_n;
  logic [31:0] instruction;
  logic        reg_write;
  logic [31:0] write_data;
  logic [63:0] write_data_p;
  logic [4:0]  dbg_addr;
  logic [3:0]  dbg_addr_p;

  logic [31:0] rd1, rd2, dbgd, rd1_nb, rd2_nb, dbgd_nb;
  logic [63:0] rd1_p, rd2_p, dbgd_p;
  logic        done, done_nb, done_p;

  int checks = 0;
  int errors = 0;

  regfile_multiport u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instruction(instruction),
    .reg_write  (reg_write),
    .write_data (write_data),
    .read_data_1(rd1),
    .read_data_2(rd2),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbgd),
    .init_done  (done)
  );

  regfile_multiport #(.BYPASS(1'b0)) u_dut_nb (
    .clk        (clk),
    .rst_n      (rst_n),
    .instruction(instruction),
    .reg_write  (reg_write),
    .write_data (write_data),
    .read_data_1(rd1_nb),
    .read_data_2(rd2_nb),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbgd_nb),
    .init_done  (done_nb)
  );

  regfile_multiport #(.XLEN(64), .NREGS(16)) u_dut_p (
    .clk        (clk),
    .rst_n      (rst_n),
    .instruction(instruction),
    .reg_write  (reg_write),
    .write_data (write_data_p),
    .read_data_1(rd1_p),
    .read_data_2(rd2_p),
    .dbg_addr   (dbg_addr_p),
    .dbg_data   (dbgd_p),
    .init_done  (done_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  dbg;
    logic [31:0] wd;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] ed;
    logic [31:0] n1;
    logic [31:0] n2;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] ed;
    logic [31:0] n1;
    logic [31:0] n2;
  } exp_t;

  exp_t sb[$];

  function automatic logic [31:0] mk_instr(input logic [4:0] rs1, input logic [4:0] rs2,
                                           input logic [4:0] rd);
    return {7'b0, rs2, rs1, 3'b0, rd, 7'b0110011};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  vec_t vecs[12];

  initial begin
    exp_t e;

    // {we, rd, rs1, rs2, dbg, wd, bypass rd1, rd2, dbg, no-bypass rd1, rd2}
    vecs[0]  = '{1'b1, 5'd5,  5'd5,  5'd6,  5'd5,  32'hDEADBEEF,
                 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[1]  = '{1'b0, 5'd0,  5'd5,  5'd6,  5'd5,  32'h0,
                 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0};
    vecs[2]  = '{1'b1, 5'd0,  5'd0,  5'd5,  5'd0,  32'h12345678,
                 32'h0, 32'hDEADBEEF, 32'h0, 32'h0, 32'hDEADBEEF};
    vecs[3]  = '{1'b0, 5'd0,  5'd0,  5'd0,  5'd0,  32'h0,
                 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[4]  = '{1'b1, 5'd7,  5'd7,  5'd7,  5'd7,  32'h1,
                 32'h1, 32'h1, 32'h0, 32'h0, 32'h0};
    vecs[5]  = '{1'b1, 5'd7,  5'd7,  5'd7,  5'd7,  32'hA5A5A5A5,
                 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h1, 32'h1, 32'h1};
    vecs[6]  = '{1'b0, 5'd0,  5'd7,  5'd5,  5'd7,  32'h0,
                 32'hA5A5A5A5, 32'hDEADBEEF, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hDEADBEEF};
    vecs[7]  = '{1'b1, 5'd31, 5'd31, 5'd30, 5'd31, 32'hCAFEF00D,
                 32'hCAFEF00D, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[8]  = '{1'b1, 5'd30, 5'd31, 5'd30, 5'd30, 32'h0F0F0F0F,
                 32'hCAFEF00D, 32'h0F0F0F0F, 32'h0, 32'hCAFEF00D, 32'h0};
    vecs[9]  = '{1'b0, 5'd0,  5'd30, 5'd31, 5'd31, 32'h0,
                 32'h0F0F0F0F, 32'hCAFEF00D, 32'hCAFEF00D, 32'h0F0F0F0F, 32'hCAFEF00D};
    vecs[10] = '{1'b1, 5'd6,  5'd5,  5'd7,  5'd6,  32'h11111111,
                 32'hDEADBEEF, 32'hA5A5A5A5, 32'h0, 32'hDEADBEEF, 32'hA5A5A5A5};
    vecs[11] = '{1'b0, 5'd0,  5'd6,  5'd6,  5'd6,  32'h0,
                 32'h11111111, 32'h11111111, 32'h11111111, 32'h11111111, 32'h11111111};

    rst_n        = 1'b0;
    instruction  = mk_instr(5'd5, 5'd9, 5'd0);
    reg_write    = 1'b0;
    write_data   = '0;
    write_data_p = '0;
    dbg_addr     = 5'd5;
    dbg_addr_p   = 4'd5;

    // Reset and full clear sequence.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_init_done", {63'b0, done}, 64'd0);
    chk("rst_init_done_p", {63'b0, done_p}, 64'd0);
    chk("rst_rd1", {32'b0, rd1}, 64'd0);
    chk("rst_dbg", {32'b0, dbgd}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("clr_done_e%0d", i), {63'b0, done}, {63'b0, i >= 32});
      chk($sformatf("clr_done_nb_e%0d", i), {63'b0, done_nb}, {63'b0, i >= 32});
      chk($sformatf("clr_done_p_e%0d", i), {63'b0, done_p}, {63'b0, i >= 16});
      if (i == 5) begin
        chk("clr_rd1_forced", {32'b0, rd1}, 64'd0);
        chk("clr_rd2_forced", {32'b0, rd2}, 64'd0);
      end
    end
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      dbg_addr   = 5'(i);
      dbg_addr_p = 4'(i);
      #1;
      chk($sformatf("sweep_dbg%0d", i), {32'b0, dbgd}, 64'd0);
      if (i < 16) chk($sformatf("sweep_dbg_p%0d", i), dbgd_p, 64'd0);
    end

    // Table-driven vectors through the scoreboard queue.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      instruction = mk_instr(vecs[i].rs1, vecs[i].rs2, vecs[i].rd);
      reg_write   = vecs[i].we;
      write_data  = vecs[i].wd;
      dbg_addr    = vecs[i].dbg;
      sb.push_back('{i, vecs[i].e1, vecs[i].e2, vecs[i].ed, vecs[i].n1, vecs[i].n2});
      #1;
      if (sb.size() == 0) begin
        chk("sb_underflow", 64'd0, 64'd1);
      end else begin
        e = sb.pop_front();
        chk($sformatf("v%0d_rd1", e.idx), {32'b0, rd1}, {32'b0, e.e1});
        chk($sformatf("v%0d_rd2", e.idx), {32'b0, rd2}, {32'b0, e.e2});
        chk($sformatf("v%0d_dbg", e.idx), {32'b0, dbgd}, {32'b0, e.ed});
        chk($sformatf("v%0d_rd1_nb", e.idx), {32'b0, rd1_nb}, {32'b0, e.n1});
        chk($sformatf("v%0d_rd2_nb", e.idx), {32'b0, rd2_nb}, {32'b0, e.n2});
        chk($sformatf("v%0d_dbg_nb", e.idx), {32'b0, dbgd_nb}, {32'b0, e.ed});
      end
    end
    chk("sb_empty", 64'(sb.size()), 64'd0);

    // Wide build: rs1 field 20 truncates to index 4.
    @(negedge clk);
    instruction  = mk_instr(5'd0, 5'd0, 5'd4);
    reg_write    = 1'b1;
    write_data   = 32'h44444444;
    write_data_p = 64'hFFFF_0000_FFFF_0000;
    @(negedge clk);
    reg_write   = 1'b0;
    instruction = mk_instr(5'd20, 5'd4, 5'd0);
    dbg_addr_p  = 4'd4;
    #1;
    chk("p_rd1_trunc", rd1_p, 64'hFFFF_0000_FFFF_0000);
    chk("p_rd2", rd2_p, 64'hFFFF_0000_FFFF_0000);
    chk("p_dbg", dbgd_p, 64'hFFFF_0000_FFFF_0000);
    chk("x20_untouched", {32'b0, rd1}, 64'd0);
    chk("x4_written", {32'b0, rd2}, 64'h44444444);

    // Mid-clear reset with writes attempted during CLEAR.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n        = 1'b1;
    instruction  = mk_instr(5'd3, 5'd3, 5'd3);
    reg_write    = 1'b1;
    write_data   = 32'hBAD0BAD0;
    write_data_p = 64'hBAD0BAD0_BAD0BAD0;
    dbg_addr     = 5'd3;
    dbg_addr_p   = 4'd3;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("mc1_done_e%0d", c), {63'b0, done}, 64'd0);
      chk($sformatf("mc1_rd1_e%0d", c), {32'b0, rd1}, 64'd0);
      chk($sformatf("mc1_rd1_p_e%0d", c), rd1_p, 64'd0);
    end
    rst_n = 1'b0;
    #2;
    chk("mc_pulse_done", {63'b0, done}, 64'd0);
    chk("mc_pulse_done_p", {63'b0, done_p}, 64'd0);
    #1;
    rst_n = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      @(posedge clk);
      #1;
      if (i == 5) reg_write = 1'b0;
      chk($sformatf("mc2_done_e%0d", i), {63'b0, done}, {63'b0, i >= 32});
      chk($sformatf("mc2_done_p_e%0d", i), {63'b0, done_p}, {63'b0, i >= 16});
    end
    #1;
    chk("mc_x3_rd1", {32'b0, rd1}, 64'd0);
    chk("mc_x3_dbg", {32'b0, dbgd}, 64'd0);
    chk("mc_x3_rd1_nb", {32'b0, rd1_nb}, 64'd0);
    chk("mc_x3_dbg_p", dbgd_p, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
